// File: rtl/imdct_ola_engine.sv
// IMDCT windowing / overlap-add engine: streams CH*N coefficients, multiplies each by a
// twiddle pair, adds the stored overlap tail from the previous frame and writes saturated words.
module imdct_ola_engine #(
    parameter int          N    = 256,
    parameter int          CH   = 2,
    parameter int          DW   = 16,
    parameter int          TW   = 16,
    parameter int          OW   = 32,
    parameter int          SH   = 14,
    parameter logic [31:0] BASE = 32'd0
) (
    input  logic                        clk_in,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        ola_flush,
    input  logic                        intr_clr,
    output logic [$clog2(CH*N)-1:0]     in_addr,
    input  logic [DW-1:0]               in_data,
    output logic [$clog2(N)-1:0]        tw_addr,
    input  logic [TW-1:0]               t1,
    input  logic [TW-1:0]               t2,
    output logic [31:0]                 out_addr,
    output logic [OW-1:0]               out_data,
    output logic [3:0]                  out_we,
    output logic                        out_en,
    output logic                        busy,
    output logic                        done,
    output logic                        intr
);
    localparam int TOT = CH * N;
    localparam int AW  = $clog2(TOT);
    localparam int KW  = $clog2(N);
    localparam int PW  = DW + TW;
    localparam logic [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     j_q, j_d;
    logic              drain_q, drain_d;
    logic              v1_q;
    logic [AW-1:0]     j1_q;
    logic [CH-1:0]     ola_valid_q, valid_d;
    logic [OW-1:0]     tail_q [TOT];
    logic [31:0]       out_addr_q;
    logic [OW-1:0]     out_data_q;
    logic [3:0]        out_we_q;
    logic              out_en_q, done_q, intr_q;

    logic signed [PW-1:0] p1_s, p2_s, p1_sh_s, p2_sh_s;
    logic signed [OW-1:0] p1_o_s, p2_o_s;
    logic [AW-1:0]        ch1_s;
    logic                 hist_ok_s, last_s;
    logic [OW-1:0]        tail_s, sat_s;
    logic [OW:0]          sum_s;
    logic [31:0]          addr_s;

    // Sequencer: walks j through every channel/sample, then drains the 2-stage pipeline.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    j_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (j_q == AW'(TOT - 1)) begin
                    state_d = DRAIN;
                    j_d     = '0;
                    drain_d = 1'b0;
                end else begin
                    j_d = j_q + AW'(1);
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            j_q     <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            drain_q <= drain_d;
        end
    end

    assign p1_s    = $signed(in_data) * $signed(t1);
    assign p2_s    = $signed(in_data) * $signed(t2);
    assign p1_sh_s = p1_s >>> SH;
    assign p2_sh_s = p2_s >>> SH;
    assign p1_o_s  = OW'(p1_sh_s);
    assign p2_o_s  = OW'(p2_sh_s);
    assign ch1_s   = j1_q >> KW;
    assign last_s  = (j1_q[KW-1:0] == {KW{1'b1}});
    assign addr_s  = BASE + (32'(j1_q) << 2);

    // History lookup for the channel being written; a cleared flag masks stale tail contents.
    always_comb begin
        hist_ok_s = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (ch1_s == AW'(c)) begin
                hist_ok_s = ola_valid_q[c];
            end else begin
                hist_ok_s = hist_ok_s;
            end
        end
        tail_s = hist_ok_s ? tail_q[j1_q] : '0;
        sum_s  = {tail_s[OW-1], tail_s} + {p1_o_s[OW-1], p1_o_s};
    end

    // Saturating add: overflow shows as the two top bits of the widened sum disagreeing.
    always_comb begin
        if (sum_s[OW] != sum_s[OW-1]) begin
            sat_s = sum_s[OW] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_s = sum_s[OW-1:0];
        end
    end

    // Overlap flags: flush only while idle, otherwise mark a channel once its last sample lands.
    always_comb begin
        valid_d = ola_valid_q;
        if ((state_q == IDLE) && ola_flush) begin
            valid_d = '0;
        end else if (v1_q && last_s) begin
            for (int c = 0; c < CH; c++) begin
                if (ch1_s == AW'(c)) begin
                    valid_d[c] = 1'b1;
                end else begin
                    valid_d[c] = ola_valid_q[c];
                end
            end
        end else begin
            valid_d = ola_valid_q;
        end
    end

    // Pipeline, write port, status and overlap flag registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            j1_q        <= '0;
            out_en_q    <= 1'b0;
            out_we_q    <= 4'h0;
            out_addr_q  <= 32'd0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            intr_q      <= 1'b0;
            ola_valid_q <= '0;
        end else begin
            v1_q        <= (state_q == RUN);
            j1_q        <= j_q;
            out_en_q    <= v1_q;
            out_we_q    <= v1_q ? 4'hF : 4'h0;
            if (v1_q) begin
                out_addr_q <= addr_s;
                out_data_q <= sat_s;
            end
            done_q      <= (state_q == DONE);
            if (state_q == DONE) begin
                intr_q <= 1'b1;
            end else if (intr_clr) begin
                intr_q <= 1'b0;
            end
            ola_valid_q <= valid_d;
        end
    end

    // Overlap store: contents are never reset because ola_valid masks them.
    always_ff @(posedge clk_in) begin
        if (v1_q) begin
            tail_q[j1_q] <= p2_o_s;
        end
    end

    assign in_addr  = j_q;
    assign tw_addr  = j_q[KW-1:0];
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign out_we   = out_we_q;
    assign out_en   = out_en_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign intr     = intr_q;
endmodule

// File: doc/imdct_ola_engine.md
IMDCT_OLA_ENGINE -- requirements
Module: imdct_ola_engine

Interface
REQ-001 SHALL have parameter N, default 256, meaning samples per channel frame (power of 2, 4..1024).
REQ-002 SHALL have parameter CH, default 2, meaning channel count (1..8).
REQ-003 SHALL have parameter DW, default 16, meaning signed coefficient width.
REQ-004 SHALL have parameter TW, default 16, meaning signed twiddle width.
REQ-005 SHALL have parameter OW, default 32, meaning signed output width.
REQ-006 SHALL have parameter SH, default 14, meaning arithmetic right-shift applied to each product.
REQ-007 SHALL have parameter BASE, default 0, meaning output byte-address base.
REQ-008 SHALL have one clock and an asynchronous active-high reset: clk_in input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1 bit: frame-start pulse.
REQ-010 SHALL have port ola_flush, input, 1 bit: clear all overlap history.
REQ-011 SHALL have port intr_clr, input, 1 bit: clear intr.
REQ-012 SHALL have port in_addr, output, clog2(CH*N) bits: coefficient read address.
REQ-013 SHALL have port in_data, input, DW bits: coefficient, valid 1 cycle after in_addr.
REQ-014 SHALL have port tw_addr, output, clog2(N) bits: twiddle ROM address.
REQ-015 SHALL have ports t1 and t2, input, TW bits each: twiddles, valid 1 cycle after tw_addr.
REQ-016 SHALL have port out_addr, output, 32 bits: byte address.
REQ-017 SHALL have port out_data, output, OW bits: write data.
REQ-018 SHALL have port out_we, output, 4 bits: byte enables.
REQ-019 SHALL have port out_en, output, 1 bit: port enable.
REQ-020 SHALL have ports busy, done and intr, output, 1 bit each: busy status; done pulse; sticky interrupt.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; reset state is IDLE.
REQ-022 IDLE->RUN SHALL occur on start=1; busy=1 from the next cycle until the return to IDLE.
REQ-023 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-024 RUN SHALL issue one sample index per cycle, ch-major: j = ch*N + k, k = 0..N-1, ch = 0..CH-1; in_addr = j and tw_addr = k.
REQ-025 RUN->DRAIN SHALL occur after index CH*N-1 is issued.
REQ-026 DRAIN SHALL last exactly 2 cycles and then go to DONE.
REQ-027 DONE SHALL pulse done=1 for 1 cycle, set intr=1, and go to IDLE.
REQ-028 Pipeline: index issued at cycle c SHALL produce a write at cycle c+2 with out_en=1, out_we=4'hF, out_addr = BASE + 4*j.
REQ-029 Outside writes, out_en=0 and out_we=0.
REQ-030 Products SHALL be p1 = in_data*t1 and p2 = in_data*t2, each signed DW+TW bits, arithmetic-shifted right by SH and sign-extended or truncated to OW.
REQ-031 out_data SHALL be sat_OW(tail[j] + (p1>>>SH)), where sat_OW saturates to signed OW min/max.
REQ-032 The internal overlap store SHALL hold CH*N words of OW bits; in the write cycle, tail[j] SHALL be replaced by p2>>>SH.
REQ-033 A per-channel flag ola_valid[ch] SHALL make tail[j] read as 0 when clear.
REQ-034 ola_valid[ch] SHALL be set when channel ch's last sample is written.
REQ-035 ola_flush in IDLE SHALL clear all ola_valid flags in one cycle; ola_flush outside IDLE SHALL be ignored.
REQ-036 intr_clr SHALL clear intr; if intr_clr and the DONE set occur in the same cycle, set SHALL win.
REQ-037 If start and ola_flush occur together in IDLE, the flush SHALL apply first, so the frame sees zero history.
REQ-038 Total latency SHALL be CH*N+4 cycles from start to done.

Reset
REQ-039 While rst=1: state IDLE; in_addr, tw_addr, out_addr, out_data, out_we, out_en, busy, done and intr = 0; all ola_valid cleared.
REQ-040 Reset mid-frame SHALL abort immediately, with no further writes after release; the next frame sees zero history.
REQ-041 Overlap store contents need no reset (masked by ola_valid).

Verification (N=4, CH=2, SH=14, BASE=0)
REQ-042 rst=1, then release -> all outputs 0; start=1 with in_data=16384, t1=16384, t2=8192 -> 8 writes at addr 0,4,...,28, data=16384 each, done at cycle 12, intr=1.
REQ-043 Second frame, identical inputs -> each out_data = 8192 + 16384 = 24576.
REQ-044 ola_flush then start -> out_data = 16384 (history zeroed); ola_flush during RUN -> no effect.
REQ-045 in_data=32767, t1=32767, SH=0, tail near max -> out_data = 2147483647 (saturated); negative case -> -2147483648.
REQ-046 rst=1 at write 3 of the frame -> out_en=0 immediately; next frame data equals first-frame values; intr_clr coincident with DONE -> intr stays 1.
